// File: rtl/light_input_conditioner_pkg.sv
// Shared encodings and the colour priority helper for the light input conditioner.
package light_pkg;

  localparam int unsigned NUM_COLOURS = 3;
  localparam int unsigned IDX_GREEN   = 0;
  localparam int unsigned IDX_YELLOW  = 1;
  localparam int unsigned IDX_RED     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_RED    = 2'd3
  } state_t;

  // Red beats yellow beats green; nothing pressed resolves to idle.
  function automatic state_t pick(input logic [NUM_COLOURS-1:0] deb);
    state_t res;
    if (deb[IDX_RED])         res = ST_RED;
    else if (deb[IDX_YELLOW]) res = ST_YELLOW;
    else if (deb[IDX_GREEN])  res = ST_GREEN;
    else                      res = ST_IDLE;
    return res;
  endfunction

  function automatic logic multi_active(input logic [NUM_COLOURS-1:0] deb);
    return (deb[IDX_GREEN] & deb[IDX_YELLOW]) |
           (deb[IDX_GREEN] & deb[IDX_RED]) |
           (deb[IDX_YELLOW] & deb[IDX_RED]);
  endfunction

endpackage

// File: rtl/light_input_conditioner_debounce_cell.sv
// Synchroniser chain followed by a consecutive-sample debouncer for one raw button.
module debounce_cell #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Counter restarts on every agreement and after each accepted toggle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (sync_bit == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        dout  <= ~dout;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/light_input_conditioner.sv
// Conditions three raw colour buttons into a mutually exclusive, minimum-hold colour state.
module light_input_conditioner
  import light_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_HOLD        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_green,
  input  logic       raw_yellow,
  input  logic       raw_red,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic       changed,
  output logic       conflict,
  output logic [1:0] state
);

  localparam int unsigned HOLD_W = $clog2(MIN_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

  logic [NUM_COLOURS-1:0] raw_vec;
  logic [NUM_COLOURS-1:0] deb;

  state_t              state_q, state_d, sel;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                enter;
  logic                changed_d, conflict_d;
  logic                green_d, yellow_d, red_d;

  assign raw_vec = {raw_red, raw_yellow, raw_green};

  for (genvar i = 0; i < NUM_COLOURS; i++) begin : g_deb
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .din   (raw_vec[i]),
      .dout  (deb[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      changed  <= 1'b0;
      conflict <= 1'b0;
      green    <= 1'b0;
      yellow   <= 1'b0;
      red      <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      changed  <= changed_d;
      conflict <= conflict_d;
      green    <= green_d;
      yellow   <= yellow_d;
      red      <= red_d;
    end
  end

  // Inputs are ignored while the hold counter is running; it saturates at zero.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    enter   = 1'b0;
    sel     = pick(deb);

    if (state_q == ST_IDLE) begin
      if (sel != ST_IDLE) begin
        state_d = sel;
        hold_d  = HOLD_LOAD;
        enter   = 1'b1;
      end
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else if (sel != state_q) begin
      state_d = sel;
      if (sel != ST_IDLE) begin
        hold_d = HOLD_LOAD;
        enter  = 1'b1;
      end
    end

    changed_d  = (state_d != state_q);
    conflict_d = enter & multi_active(deb);
    green_d    = (state_d == ST_GREEN);
    yellow_d   = (state_d == ST_YELLOW);
    red_d      = (state_d == ST_RED);
  end

  assign state = state_q;

endmodule
